softmax_vec_loader: RTL and testbench
=====================================

Name: softmax_vec_loader

Overview:
Front-end producer for the softmax pipeline. It accepts Q4.12 scores one element per cycle over a valid/ready stream, packs them into an N-lane flat vector, and tracks the running signed maximum. Once a vector is complete, it emits a one-cycle valid_out pulse carrying the vector, its max, and the lane count. These outputs drive the softmax valid_in, in_x_flat and max_x inputs directly.

Parameters:
N, 8, number of lanes per vector; must match the downstream softmax N.
LW, $clog2(N+1), width of the lane-count output.

Ports:
clk  input  1  clock; all registers update on the rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  global pipeline enable, shared with the softmax stage; when low, all state is frozen.
valid_in  input  1  x_in is valid this cycle.
x_in  input  16  one score, signed Q4.12.
last_in  input  1  marks the final element of a vector; only meaningful when valid_in is high.
ready  output  1  loader can accept an element this cycle.
valid_out  output  1  one-cycle pulse: out_x_flat, max_x and len_out are valid.
out_x_flat  output  N*16  packed vector; element k sits at bits [k*16 +: 16].
max_x  output  16  signed maximum of the valid lanes.
len_out  output  LW  number of valid lanes, 1..N.

Behaviour:
- Reset (asynchronous, any time including mid-vector):
  - valid_out=0, out_x_flat=0, max_x=0, len_out=0.
  - Lane counter cnt=0, running max=16'h8000.
  - Collect buffer: every lane = 16'h8000 (PAD).
- ready = en. Acceptance means valid_in & ready; there is no other backpressure.
- On acceptance:
  - Lane[cnt] <= x_in.
  - Running max <= signed max(running max, x_in).
  - cnt <= cnt+1.
- Final element: an accepted element where last_in=1 or cnt==N-1. In that cycle:
  - out_x_flat <= collect buffer with the new element merged in; unwritten lanes keep PAD.
  - max_x <= signed max(running max, x_in).
  - len_out <= cnt+1.
  - valid_out <= 1 on the next edge.
  - Collect buffer <= all PAD, cnt <= 0, running max <= 16'h8000, all on the same edge.
- Latency: valid_out rises the cycle after the final element is accepted.
- Throughput: the element after a final element may be accepted in the very next cycle. Back-to-back vectors are lossless, with no bubble required.
- valid_out deasserts after one enabled cycle unless another final element is accepted in that cycle, in which case it stays high and the outputs update.
- en=0:
  - No acceptance; every register holds, including valid_out and the outputs.
  - The downstream stage is frozen by the same en, so a held pulse is consumed exactly once.
- PAD 16'h8000 (-8.0) forces exp(pad - max) to underflow to about 0, so short vectors need no downstream change.
- last_in together with cnt==N-1 is treated as a single final event.
- last_in without valid_in is ignored.
- Arithmetic: two's-complement compares on 16 bits; no saturation or rounding. x_in is stored bit-exact.

Decomposition:
- Shared package, constants only:
  - Q_WIDTH=16.
  - Q_FRAC=12.
  - Q_NEG_MAX=16'h8000, used as PAD and as the max reset value.
- Sub-module run_max_q412:
  - Signed comparator plus max register, with clear-on-final and en gating.
  - Also outputs the combinational max including the current element, for the same-cycle handoff.
- Lane buffer, counter and output registers stay in the top level.

Test Plan (N=4 unless noted):
1. Full vector. Accept 0x1000, 0x2000, 0xF000, 0x0800 on consecutive cycles.
   -> One cycle after the 4th: valid_out=1 for exactly one cycle, out_x_flat={0x0800,0xF000,0x2000,0x1000} (lane3..lane0), max_x=0x2000, len_out=4.
2. Short vector. Accept 0xF000, then 0xE000 with last_in=1.
   -> out_x_flat={0x8000,0x8000,0xE000,0xF000}, max_x=0xF000, len_out=2.
3. Back-to-back. Vector A = 0x1000 x4, immediately followed by vector B = 0xC000, 0xD000, 0xC000, 0xC000, with valid_in held high.
   -> Two pulses 4 cycles apart. B gives max_x=0xD000, with no carry-over from A.
4. en stall. Drop en for 3 cycles after 2 elements, with valid_in held high.
   -> ready=0 and nothing is accepted during the stall; the result is identical to case 1.
   -> If en drops on the valid_out cycle, valid_out stays 1 until en returns, then clears after one enabled cycle.
5. Reset mid-vector. Assert rst asynchronously after 2 elements.
   -> Outputs and cnt clear immediately. The next 4 elements form a fresh vector whose max_x reflects only those elements.
6. Extreme values. Accept 0x8000, 0x7FFF, 0x8000, 0x8000.
   -> max_x=0x7FFF (signed compare), len_out=4, and valid_out pulses once.

Source files
------------

// File: rtl/softmax_vec_loader_pkg.sv
// Shared Q4.12 fixed-point constants for the softmax front-end.
package softmax_vec_loader_pkg;
   localparam int Q_WIDTH = 16;
   localparam int Q_FRAC  = 12;
   // Most negative Q4.12 value: lane padding and the identity for a running max.
   localparam logic [Q_WIDTH-1:0] Q_NEG_MAX = 16'h8000;
endpackage

// File: rtl/run_max_q412.sv
// Running signed max of a Q4.12 element stream.
// Clears when the final element of a vector is taken.
module run_max_q412
   import softmax_vec_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               acc,
   input  logic               clr,
   input  logic [Q_WIDTH-1:0] x,
   output logic [Q_WIDTH-1:0] max_nxt
);
   logic [Q_WIDTH-1:0] max_q;

   // Includes the current element so the vector's max can be handed off
   // on the same edge that clears the register.
   assign max_nxt = ($signed(x) > $signed(max_q)) ? x : max_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         max_q <= Q_NEG_MAX;
      else if (en && acc)
         max_q <= clr ? Q_NEG_MAX : max_nxt;
   end
endmodule

// File: rtl/softmax_vec_loader.sv
// Packs a Q4.12 element stream into N-lane vectors with a per-vector max.
// Emits a one-cycle valid_out pulse (held while en is low) per vector.
module softmax_vec_loader
   import softmax_vec_loader_pkg::*;
#(
   parameter int N  = 8,
   parameter int LW = $clog2(N+1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 valid_in,
   input  logic [Q_WIDTH-1:0]   x_in,
   input  logic                 last_in,
   output logic                 ready,
   output logic                 valid_out,
   output logic [N*Q_WIDTH-1:0] out_x_flat,
   output logic [Q_WIDTH-1:0]   max_x,
   output logic [LW-1:0]        len_out
);
   logic [N-1:0][Q_WIDTH-1:0] lanes, merged, out_lanes;
   logic [LW-1:0]             cnt;
   logic                      acc, fin;
   logic [Q_WIDTH-1:0]        max_nxt;

   assign ready      = en;
   assign acc        = valid_in & en;
   assign fin        = acc & (last_in | (cnt == LW'(N-1)));
   assign out_x_flat = out_lanes;

   always_comb begin
      merged = lanes;
      for (int k = 0; k < N; k++)
         if (cnt == LW'(k)) merged[k] = x_in;
   end

   run_max_q412 u_max (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .acc     (acc),
      .clr     (fin),
      .x       (x_in),
      .max_nxt (max_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lanes     <= {N{Q_NEG_MAX}};
         cnt       <= '0;
         valid_out <= 1'b0;
         out_lanes <= '0;
         max_x     <= '0;
         len_out   <= '0;
      end else if (en) begin
         valid_out <= fin;
         if (fin) begin
            out_lanes <= merged;
            max_x     <= max_nxt;
            len_out   <= cnt + LW'(1);
            lanes     <= {N{Q_NEG_MAX}};
            cnt       <= '0;
         end else if (acc) begin
            lanes <= merged;
            cnt   <= cnt + LW'(1);
         end
      end
   end
endmodule

// File: tb/tb_softmax_vec_loader.sv
// Bench for softmax_vec_loader (N=4): queue-based vector model checked every
// cycle, plus literal expectations on each captured output pulse.
module tb_softmax_vec_loader;
   localparam int N  = 4;
   localparam int LW = $clog2(N+1);

   logic          clk = 0, rst = 1, en = 1, valid_in = 0, last_in = 0;
   logic [15:0]   x_in = '0;
   logic          ready, valid_out;
   logic [63:0]   out_x_flat;
   logic [15:0]   max_x;
   logic [LW-1:0] len_out;

   int checks = 0, errors = 0, cyc = 0;

   softmax_vec_loader #(.N(N)) dut (
      .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .x_in(x_in),
      .last_in(last_in), .ready(ready), .valid_out(valid_out),
      .out_x_flat(out_x_flat), .max_x(max_x), .len_out(len_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: elements of the vector being collected, plus the last published result.
   logic [15:0] cur_q[$];
   logic        m_vout = 0;
   logic [63:0] m_flat = '0;
   logic [15:0] m_max  = '0;
   int          m_len  = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_q.delete();
         m_vout = 0; m_flat = '0; m_max = '0; m_len = 0;
      end else if (en) begin
         m_vout = 0;
         if (valid_in) begin
            cur_q.push_back(x_in);
            if (last_in || cur_q.size() == N) begin
               m_len  = cur_q.size();
               m_max  = cur_q[0];
               m_flat = {N{16'h8000}};
               for (int k = 0; k < cur_q.size(); k++) begin
                  m_flat[k*16 +: 16] = cur_q[k];
                  if ($signed(cur_q[k]) > $signed(m_max)) m_max = cur_q[k];
               end
               m_vout = 1;
               cur_q.delete();
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("ready", 64'(ready), 64'(en));
      chk("valid_out", 64'(valid_out), 64'(m_vout));
      chk("out_x_flat", out_x_flat, m_flat);
      chk("max_x", 64'(max_x), 64'(m_max));
      chk("len_out", 64'(len_out), 64'(m_len));
   end

   // Each pulse counted once: on the enabled cycle that consumes it.
   typedef struct { logic [63:0] flat; logic [15:0] mx; int len; int c; } pulse_t;
   pulse_t pulses[$];
   always @(negedge clk)
      if (!rst && en && valid_out)
         pulses.push_back('{out_x_flat, max_x, int'(len_out), cyc});

   task automatic send(input logic [15:0] x, input logic last);
      valid_in = 1; x_in = x; last_in = last;
      @(posedge clk); #1;
      valid_in = 0; last_in = 0;
   endtask

   task automatic idle(input int n);
      valid_in = 0; last_in = 0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_pulses(input string name, input int n);
      chk({name, "_npulses"}, 64'(pulses.size()), 64'(n));
   endtask

   task automatic expect_pulse(input string name, input logic [63:0] f, input logic [15:0] m, input int l);
      pulse_t p;
      if (pulses.size() == 0) begin
         chk({name, "_present"}, 64'(0), 64'(1));
      end else begin
         p = pulses.pop_front();
         chk({name, "_flat"}, p.flat, f);
         chk({name, "_max"}, 64'(p.mx), 64'(m));
         chk({name, "_len"}, 64'(p.len), 64'(l));
      end
   endtask

   initial begin
      pulse_t pa, pb;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid_out", 64'(valid_out), 64'(0));
      chk("reset_flat", out_x_flat, 64'(0));
      chk("reset_max", 64'(max_x), 64'(0));
      chk("reset_len", 64'(len_out), 64'(0));
      rst = 0;
      idle(1);

      // 1. full vector
      send(16'h1000, 0); send(16'h2000, 0); send(16'hF000, 0); send(16'h0800, 0);
      chk("t1_pulse_now", 64'(valid_out), 64'(1));
      idle(1);
      chk("t1_pulse_one_cycle", 64'(valid_out), 64'(0));
      idle(2);
      expect_pulses("t1", 1);
      expect_pulse("t1", 64'h0800_F000_2000_1000, 16'h2000, 4);

      // 2. short vector
      send(16'hF000, 0); send(16'hE000, 1);
      idle(3);
      expect_pulses("t2", 1);
      expect_pulse("t2", 64'h8000_8000_E000_F000, 16'hF000, 2);

      // 3. back-to-back vectors
      repeat (4) send(16'h1000, 0);
      send(16'hC000, 0); send(16'hD000, 0); send(16'hC000, 0); send(16'hC000, 0);
      idle(3);
      expect_pulses("t3", 2);
      if (pulses.size() == 2) begin
         pa = pulses[0]; pb = pulses[1];
         chk("t3_spacing", 64'(pb.c - pa.c), 64'(4));
      end
      expect_pulse("t3a", 64'h1000_1000_1000_1000, 16'h1000, 4);
      expect_pulse("t3b", 64'hC000_C000_D000_C000, 16'hD000, 4);

      // 4a. en stall mid-vector with valid_in held high
      send(16'h1000, 0); send(16'h2000, 0);
      valid_in = 1; x_in = 16'hF000; en = 0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("t4_ready_low", 64'(ready), 64'(0));
      end
      en = 1;
      send(16'hF000, 0); send(16'h0800, 0);
      idle(3);
      expect_pulses("t4a", 1);
      expect_pulse("t4a", 64'h0800_F000_2000_1000, 16'h2000, 4);

      // 4b. en drops while valid_out is high
      send(16'h1000, 0); send(16'h2000, 0); send(16'hF000, 0); send(16'h0800, 0);
      en = 0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("t4b_held", 64'(valid_out), 64'(1));
      end
      en = 1;
      @(posedge clk); #1;
      chk("t4b_cleared", 64'(valid_out), 64'(0));
      idle(2);
      expect_pulses("t4b", 1);
      expect_pulse("t4b", 64'h0800_F000_2000_1000, 16'h2000, 4);

      // 5. async reset mid-vector
      send(16'h7000, 0); send(16'h6000, 0);
      #2 rst = 1;
      #1;
      chk("t5_rst_flat", out_x_flat, 64'(0));
      chk("t5_rst_max", 64'(max_x), 64'(0));
      chk("t5_rst_len", 64'(len_out), 64'(0));
      @(posedge clk); #1;
      rst = 0;
      send(16'h0100, 0); send(16'h0200, 0); send(16'h0300, 0); send(16'h0050, 0);
      idle(3);
      expect_pulses("t5", 1);
      expect_pulse("t5", 64'h0050_0300_0200_0100, 16'h0300, 4);

      // 6. extreme values
      send(16'h8000, 0); send(16'h7FFF, 0); send(16'h8000, 0); send(16'h8000, 0);
      idle(3);
      expect_pulses("t6", 1);
      expect_pulse("t6", 64'h8000_8000_7FFF_8000, 16'h7FFF, 4);

      // last_in without valid_in, then last_in on lane N-1
      last_in = 1;
      @(posedge clk); #1;
      last_in = 0;
      send(16'h0001, 0); send(16'h0002, 0); send(16'h0003, 0); send(16'h0004, 1);
      idle(3);
      expect_pulses("t7", 1);
      expect_pulse("t7", 64'h0004_0003_0002_0001, 16'h0004, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end
endmodule
